serial_alu_sequencer: RTL and testbench

Bit-serial add/subtract engine built around a single FullAdder1b instance, for area-reduced ALU configurations of the RV32I core. Accepts one operation through a START/DONE handshake. Time-multiplexes the 1-bit adder over WIDTH cycles, LSB first, carrying COUT back into CIN through a register. Produces the full-width result plus carry, signed-overflow and zero flags.

---
 rtl/serial_alu_sequencer.sv | 123 ++++++++++++
 tb/tb_serial_alu_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_sequencer.sv
// Bit-serial add/subtract engine: one full adder processes the operands LSB first,
// with its carry recirculated through a register. START/DONE handshake, registered flags.

module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic             OVERFLOW,
    output logic             ZERO
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-2:0] sreg;
    logic             carry;
    logic             fa_s;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    full_adder_1b u_fa (
        .a   (areg[0]),
        .b   (breg[0]),
        .cin (carry),
        .s   (fa_s),
        .cout(fa_cout)
    );

    // START is only honoured outside RUN; a request during RUN is dropped.
    assign accept   = START && (state != ST_RUN);
    assign last_bit = (state == ST_RUN) && (cnt == LAST);
    // Bits already shifted in, with this cycle's sum bit on top: the full result on the last edge.
    assign res_next = {fa_s, sreg};

    // NOTE: the operand/sum shift registers are always reloaded or fully overwritten before
    // they are observed, so they are left without reset; only control and outputs reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            areg  <= OP_A;
            breg  <= SUB ? ~OP_B : OP_B;
            carry <= SUB;
        end else if (state == ST_RUN) begin
            areg  <= areg >> 1;
            breg  <= breg >> 1;
            sreg  <= res_next[WIDTH-1:1];
            carry <= fa_cout;
        end
    end

    // NOTE: non-blocking assignments throughout, so every decision below sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            RESULT   <= '0;
            COUT     <= 1'b0;
            OVERFLOW <= 1'b0;
            ZERO     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state <= ST_RUN;
                        BUSY  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (last_bit) begin
                        // carry still holds the carry into the MSB here.
                        state    <= ST_DONE;
                        cnt      <= '0;
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                        RESULT   <= res_next;
                        COUT     <= fa_cout;
                        OVERFLOW <= carry ^ fa_cout;
                        ZERO     <= (res_next == '0);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Scoreboarded random/directed bench for serial_alu_sequencer: stimulus pushes expected
// results from an arithmetic model, a negedge monitor pops and compares on DONE.

module tb_serial_alu_sequencer;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic         SUB = 1'b0;
    logic [W-1:0] OP_A = '0;
    logic [W-1:0] OP_B = '0;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESULT;
    logic         COUT;
    logic         OVERFLOW;
    logic         ZERO;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           busy_run = 0;
    logic [W-1:0] last_res = '0;
    logic [2:0]   last_flags = '0;

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .START   (START),
        .SUB     (SUB),
        .OP_A    (OP_A),
        .OP_B    (OP_B),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT),
        .COUT    (COUT),
        .OVERFLOW(OVERFLOW),
        .ZERO    (ZERO)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain modular arithmetic, unsigned compare for borrow, sign rules for overflow.
    function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int acc);
        exp_t       e;
        logic [W:0] wide;
        if (sub) begin
            e.res = a - b;
            e.c   = (a >= b);
            e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        end else begin
            wide  = {1'b0, a} + {1'b0, b};
            e.res = wide[W-1:0];
            e.c   = wide[W];
            e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
        end
        e.z   = (e.res == '0);
        e.acc = acc;
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            busy_run   = 0;
            last_res   = '0;
            last_flags = '0;
            sb.delete();
        end else begin
            if (BUSY) busy_run++;
            if (DONE) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(DONE), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", 64'(RESULT), 64'(e.res));
                    check("cout", 64'(COUT), 64'(e.c));
                    check("overflow", 64'(OVERFLOW), 64'(e.v));
                    check("zero", 64'(ZERO), 64'(e.z));
                    check("done_latency", 64'(cyc), 64'(e.acc + W));
                    check("busy_cycles", 64'(busy_run), 64'(W));
                    check("busy_in_done", 64'(BUSY), 64'd0);
                    last_res   = e.res;
                    last_flags = {e.c, e.v, e.z};
                end
                busy_run = 0;
            end else begin
                check("held_result", 64'(RESULT), 64'(last_res));
                check("held_flags", 64'({COUT, OVERFLOW, ZERO}), 64'(last_flags));
            end
        end
    end

    // Called between a negedge and the next posedge; returns just after the following negedge.
    task automatic issue(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
        int acc;
        START = 1'b1;
        SUB   = sub;
        OP_A  = a;
        OP_B  = b;
        acc   = cyc + 1;
        @(posedge CLK);
        sb.push_back(model(sub, a, b, acc));
        @(negedge CLK);
        #1;
        START = 1'b0;
        SUB   = 1'($urandom);
        OP_A  = $urandom;
        OP_B  = $urandom;
        check("busy_after_accept", 64'(BUSY), 64'd1);
    endtask

    // Returns at the negedge of the DONE cycle.
    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!DONE && n < 3 * W);
        if (!DONE) check("done_timeout", 64'(DONE), 64'd1);
    endtask

    logic         d_sub[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] d_a[6] = '{32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd7, 32'h8000_0000};
    logic [W-1:0] d_b[6] = '{32'd3, 32'd1, 32'd1, 32'd7, 32'd7, 32'd1};

    initial begin
        repeat (2) @(negedge CLK);
        #1;
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_result", 64'(RESULT), 64'd0);
        check("rst_cout", 64'(COUT), 64'd0);
        check("rst_overflow", 64'(OVERFLOW), 64'd0);
        check("rst_zero", 64'(ZERO), 64'd0);
        RST_N = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            #1;
            issue(d_sub[i], d_a[i], d_b[i]);
            wait_done();
        end

        // Stray START with different operands during RUN must be ignored.
        @(negedge CLK);
        #1;
        issue(1'b0, 32'h0000_1234, 32'h0000_1111);
        repeat (8) @(negedge CLK);
        #1;
        START = 1'b1;
        SUB   = 1'b1;
        OP_A  = 32'h0000_FFFF;
        OP_B  = 32'h0000_0001;
        @(negedge CLK);
        #1;
        START = 1'b0;
        wait_done();

        // Back-to-back: START held through the DONE cycle.
        @(negedge CLK);
        #1;
        issue(1'b0, 32'd100, 32'd23);
        wait_done();
        #1;
        issue(1'b1, 32'd3, 32'd10);
        wait_done();

        // Reset in the middle of RUN discards the operation.
        @(negedge CLK);
        #1;
        issue(1'b0, 32'hAAAA_AAAA, 32'h5555_5555);
        repeat (19) @(negedge CLK);
        #1;
        RST_N = 1'b0;
        @(negedge CLK);
        #1;
        check("midrst_busy", 64'(BUSY), 64'd0);
        check("midrst_done", 64'(DONE), 64'd0);
        check("midrst_result", 64'(RESULT), 64'd0);
        check("midrst_flags", 64'({COUT, OVERFLOW, ZERO}), 64'd0);
        RST_N = 1'b1;
        repeat (W + 5) @(negedge CLK);
        #1;
        issue(1'b0, 32'd2, 32'd2);
        wait_done();

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap == 0) begin
                #1;
            end else begin
                repeat (gap) @(negedge CLK);
                #1;
            end
            issue(1'($urandom), pick(), pick());
            wait_done();
        end

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
